muldiv_sequencer: RTL and testbench

Iterative RV32M multiply/divide sequencer attached to the execute stage. It accepts forwarded operands (srcA and the forwarded rs2 value) when an M-extension instruction sits in EX. It stalls the pipeline via the hazard unit while a radix-2 shift-add multiply or restoring divide runs over DATA_WIDTH cycles. It then presents the result for one cycle, to be muxed onto the EX result path alongside the ALU output.

---
 rtl/osiris_muldiv_pkg.sv | 50 +++++
 rtl/muldiv_iter_core.sv | 79 +++++++
 rtl/muldiv_sequencer.sv | 140 ++++++++++++++
 tb/tb_muldiv_sequencer.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/osiris_muldiv_pkg.sv
// rtl/osiris_muldiv_pkg.sv - RV32M funct3 decode, FSM encoding and operand-signedness helpers
package osiris_muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SEL_LO  = 2'd0,
        SEL_HI  = 2'd1,
        SEL_QUO = 2'd2,
        SEL_REM = 2'd3
    } sel_t;

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
               (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_div(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic sel_t result_sel(input logic [2:0] op);
        sel_t sel;
        case (op)
            OP_MUL:                        sel = SEL_LO;
            OP_MULH, OP_MULHSU, OP_MULHU:  sel = SEL_HI;
            OP_DIV, OP_DIVU:               sel = SEL_QUO;
            default:                       sel = SEL_REM;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// rtl/muldiv_iter_core.sv - accumulator, one shift-add / shift-subtract step and sign fix-up
// Divide step present only when MULDIV_DIV_EN is defined.
module muldiv_iter_core
    import osiris_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load,
    input  logic                  i_step,
    input  logic [DATA_WIDTH-1:0] i_lo_init,
    input  logic [DATA_WIDTH-1:0] i_mcand_init,
    input  sel_t                  i_sel,
    input  logic                  i_neg_res,
    input  logic                  i_neg_rem,
    output logic [DATA_WIDTH-1:0] o_result
);

    logic [DATA_WIDTH-1:0]   r_hi;
    logic [DATA_WIDTH-1:0]   r_lo;
    logic [DATA_WIDTH-1:0]   r_mcand;

    logic [DATA_WIDTH:0]     w_sum;
    logic [DATA_WIDTH-1:0]   w_next_hi;
    logic [DATA_WIDTH-1:0]   w_next_lo;
    logic [2*DATA_WIDTH-1:0] w_prod;
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
`ifdef MULDIV_DIV_EN
    logic                    w_is_div;
    logic [DATA_WIDTH:0]     w_shift;
    logic [DATA_WIDTH-1:0]   w_diff;
    logic                    w_ge;
`endif

    // hi:lo is the product (multiplier consumed from lo) or remainder:quotient (dividend from lo)
    always_comb begin
        w_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_mcand} : '0);
        w_next_hi = w_sum[DATA_WIDTH:1];
        w_next_lo = {w_sum[0], r_lo[DATA_WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
        w_is_div = (i_sel == SEL_QUO) || (i_sel == SEL_REM);
        w_shift  = {r_hi, r_lo[DATA_WIDTH-1]};
        w_ge     = (w_shift >= {1'b0, r_mcand});
        w_diff   = w_shift[DATA_WIDTH-1:0] - r_mcand;
        if (w_is_div) begin
            w_next_hi = w_ge ? w_diff : w_shift[DATA_WIDTH-1:0];
            w_next_lo = {r_lo[DATA_WIDTH-2:0], w_ge};
        end
`endif
    end

    always_comb begin
        w_prod     = {w_next_hi, w_next_lo};
        w_prod_fix = i_neg_res ? -w_prod : w_prod;
        case (i_sel)
            SEL_LO:  o_result = w_prod_fix[DATA_WIDTH-1:0];
            SEL_HI:  o_result = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            SEL_QUO: o_result = i_neg_res ? -w_next_lo : w_next_lo;
            default: o_result = i_neg_rem ? -w_next_hi : w_next_hi;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi    <= '0;
            r_lo    <= '0;
            r_mcand <= '0;
        end else if (i_load) begin
            r_hi    <= '0;
            r_lo    <= i_lo_init;
            r_mcand <= i_mcand_init;
        end else if (i_step) begin
            r_hi    <= w_next_hi;
            r_lo    <= w_next_lo;
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - RV32M iterative multiply/divide sequencer for the EX stage
// Define MULDIV_DIV_EN to include DIV/DIVU/REM/REMU; otherwise 1xx ops complete at once with 0.
module muldiv_sequencer
    import osiris_muldiv_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start_EX,
    input  logic [2:0]            i_muldiv_op_EX,
    input  logic [DATA_WIDTH-1:0] i_src_a_EX,
    input  logic [DATA_WIDTH-1:0] i_src_b_EX,
    input  logic                  i_flush_EX,
    output logic                  o_stall_EX,
    output logic                  o_done_EX,
    output logic [DATA_WIDTH-1:0] o_result_EX
);

    localparam int CNT_WIDTH = $clog2(DATA_WIDTH) + 1;
`ifdef MULDIV_DIV_EN
    localparam logic [DATA_WIDTH-1:0] W_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`endif

    state_t                r_state;
    state_t                w_next_state;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [2:0]            r_op;
    logic                  r_sign_a;
    logic                  r_sign_b;
    logic [DATA_WIDTH-1:0] r_result;

    logic                  w_sign_a;
    logic                  w_sign_b;
    logic                  w_is_div;
    logic                  w_accept;
    logic                  w_fast;
    logic                  w_no_stall;
    logic                  w_step;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_a_mag;
    logic [DATA_WIDTH-1:0] w_b_mag;
    logic [DATA_WIDTH-1:0] w_fast_result;
    logic [DATA_WIDTH-1:0] w_core_result;
`ifdef MULDIV_DIV_EN
    logic                  w_div_zero;
    logic                  w_div_ovf;
`endif

    always_comb begin
        w_sign_a = is_signed_a(i_muldiv_op_EX) & i_src_a_EX[DATA_WIDTH-1];
        w_sign_b = is_signed_b(i_muldiv_op_EX) & i_src_b_EX[DATA_WIDTH-1];
        w_a_mag  = w_sign_a ? -i_src_a_EX : i_src_a_EX;
        w_b_mag  = w_sign_b ? -i_src_b_EX : i_src_b_EX;
        w_is_div = is_div(i_muldiv_op_EX);
        w_accept = (r_state == ST_IDLE) & i_start_EX & ~i_flush_EX;
        w_step   = (r_state == ST_BUSY) & ~i_flush_EX;
        w_last   = w_step & (r_cnt == CNT_WIDTH'(1));
`ifdef MULDIV_DIV_EN
        // Cases whose answer is fixed by the ISA skip the iteration entirely
        w_div_zero = (i_src_b_EX == '0);
        w_div_ovf  = is_signed_b(i_muldiv_op_EX) & (i_src_a_EX == W_MIN) & (i_src_b_EX == '1);
        w_fast     = w_is_div & (w_div_zero | w_div_ovf);
        w_no_stall = 1'b0;
        if (result_sel(i_muldiv_op_EX) == SEL_QUO) begin
            w_fast_result = w_div_zero ? '1 : W_MIN;
        end else begin
            w_fast_result = w_div_zero ? i_src_a_EX : '0;
        end
`else
        w_fast        = w_is_div;
        w_no_stall    = w_is_div;
        w_fast_result = '0;
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_flush_EX) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start_EX) w_next_state = w_fast ? ST_DONE : ST_BUSY;
                ST_BUSY: if (r_cnt == CNT_WIDTH'(1)) w_next_state = ST_DONE;
                ST_DONE: w_next_state = ST_IDLE;
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        o_stall_EX = (r_state == ST_BUSY) | (w_accept & ~w_no_stall);
        o_done_EX  = (r_state == ST_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_op     <= '0;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_result <= '0;
        end else if (w_accept) begin
            r_cnt    <= CNT_WIDTH'(DATA_WIDTH);
            r_op     <= i_muldiv_op_EX;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            if (w_fast) r_result <= w_fast_result;
        end else if (w_step) begin
            r_cnt <= r_cnt - 1'b1;
            if (w_last) r_result <= w_core_result;
        end
    end

    assign o_result_EX = r_result;

    muldiv_iter_core #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_core (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_load       (w_accept),
        .i_step       (w_step),
        .i_lo_init    (w_is_div ? w_a_mag : w_b_mag),
        .i_mcand_init (w_is_div ? w_b_mag : w_a_mag),
        .i_sel        (result_sel(r_op)),
        .i_neg_res    (r_sign_a ^ r_sign_b),
        .i_neg_rem    (r_sign_a),
        .o_result     (w_core_result)
    );

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer (honours MULDIV_DIV_EN)
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        stall;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    muldiv_sequencer #(.DATA_WIDTH(32)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start_EX     (start),
        .i_muldiv_op_EX (op),
        .i_src_a_EX     (src_a),
        .i_src_b_EX     (src_b),
        .i_flush_EX     (flush),
        .o_stall_EX     (stall),
        .o_done_EX      (done),
        .o_result_EX    (result)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Architectural answer of an M-extension op, from plain 64-bit arithmetic
    function automatic logic [31:0] mdl_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        longint      ua = {32'b0, a};
        longint      ub = {32'b0, b};
        logic [63:0] p;
        case (f3)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ua; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
`ifdef MULDIV_DIV_EN
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            3'd7: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
`endif
            default: return 32'h0;
        endcase
    endfunction

    function automatic bit mdl_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
`ifdef MULDIV_DIV_EN
        return f3[2] && ((b == 0) || ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
`else
        return f3[2] || (a != a);
`endif
    endfunction

    function automatic bit mdl_stalls(input logic [2:0] f3);
`ifdef MULDIV_DIV_EN
        return f3 == f3;
`else
        return !f3[2];
`endif
    endfunction

    int          m_left = 0;
    bit          m_done = 1'b0;
    logic [31:0] m_res  = 32'h0;
    logic [31:0] m_pend = 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_left = 0;
            m_done = 1'b0;
            m_res  = 32'h0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_left > 0) begin
            if (flush) begin
                m_left = 0;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_res  = m_pend;
                end
            end
        end else if (start && !flush) begin
            m_pend = mdl_ref(op, src_a, src_b);
            if (mdl_fast(op, src_a, src_b)) begin
                m_done = 1'b1;
                m_res  = m_pend;
            end else begin
                m_left = 32;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("cyc_stall", {31'b0, stall},
                {31'b0, (m_left > 0) || (!m_done && start && !flush && mdl_stalls(op))});
            chk("cyc_done", {31'b0, done}, {31'b0, m_done});
            chk("cyc_result", result, m_res);
        end
    end

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        int          lat;
        int          stl;
    } vec_t;

    vec_t vq[$];

    task automatic run_op(input vec_t v);
        int  n_stall = 0;
        int  cyc;
        bit  seen = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        op    = v.f3;
        src_a = v.a;
        src_b = v.b;
        for (cyc = 0; cyc < 100; cyc++) begin
            @(negedge clk);
            if (stall) n_stall++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk({v.name, "_done_seen"}, {31'b0, seen}, 32'd1);
        if (seen) begin
            chk({v.name, "_result"}, result, v.res);
            chk({v.name, "_latency"}, 32'(cyc), 32'(v.lat));
            chk({v.name, "_stall_cycles"}, 32'(n_stall), 32'(v.stl));
        end
    endtask

    task automatic count_done(input int n, output int d);
        d = 0;
        repeat (n) begin
            @(negedge clk);
            if (done) d++;
        end
    endtask

    int nd;

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = 3'd0;
        src_a = 32'h0;
        src_b = 32'h0;

        vq.push_back('{"mul_7_m3",   3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, 33});
        vq.push_back('{"mulhu_max",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, 33});
        vq.push_back('{"mulhsu_m1",  3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 33, 33});
        vq.push_back('{"mulh_min2",  3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 33, 33});
        vq.push_back('{"mul_shift",  3'd0, 32'h1234_5678,  32'h10,        32'h2345_6780, 33, 33});
`ifdef MULDIV_DIV_EN
        vq.push_back('{"div_m7_2",   3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 33, 33});
        vq.push_back('{"rem_m7_2",   3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 33, 33});
        vq.push_back('{"divu_100_7", 3'd5, 32'd100,        32'd7,         32'd14,        33, 33});
        vq.push_back('{"remu_100_7", 3'd7, 32'd100,        32'd7,         32'd2,         33, 33});
        vq.push_back('{"div_by0",    3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,  1});
        vq.push_back('{"remu_by0",   3'd7, 32'd5,          32'd0,         32'd5,         1,  1});
        vq.push_back('{"div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1,  1});
        vq.push_back('{"rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1,  1});
`else
        vq.push_back('{"div_off",    3'd4, 32'd5,          32'd0,         32'd0,         1,  0});
        vq.push_back('{"remu_off",   3'd7, 32'd100,        32'd7,         32'd0,         1,  0});
`endif
        vq.push_back('{"mul_3_4",    3'd0, 32'd3,          32'd4,         32'd12,        33, 33});

        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 32'h0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_stall", {31'b0, stall}, 32'd0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        foreach (vq[i]) run_op(vq[i]);

        // Start stayed high through DONE; dropping it afterwards must leave the unit quiet
        @(posedge clk); #1;
        start = 1'b0;
        count_done(40, nd);
        chk("no_restart_done_count", 32'(nd), 32'd0);

        @(posedge clk); #1;
        start = 1'b1;
        op    = 3'd0;
        src_a = 32'd1000;
        src_b = 32'd1000;
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_cycle_stall", {31'b0, stall}, 32'd1);
        @(posedge clk); #1;
        flush = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("after_flush_stall", {31'b0, stall}, 32'd0);
        count_done(40, nd);
        chk("flush_done_count", 32'(nd), 32'd0);
        chk("flush_result_kept", result, 32'd12);

        run_op('{"mul_3_4_post", 3'd0, 32'd3, 32'd4, 32'd12, 33, 33});

        @(posedge clk); #1;
        op    = 3'd3;
        src_a = 32'h0001_0000;
        src_b = 32'h0003_0000;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        start = 1'b0;
        #2;
        chk("midbusy_rst_result", result, 32'h0);
        chk("midbusy_rst_stall", {31'b0, stall}, 32'd0);
        chk("midbusy_rst_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        count_done(40, nd);
        chk("post_rst_done_count", 32'(nd), 32'd0);

        run_op('{"mulhu_post_rst", 3'd3, 32'h0001_0000, 32'h0003_0000, 32'd3, 33, 33});
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
